// File: rtl/axi4_mem_responder_if.sv
// AXI4 bus bundle between a cache master and the memory responder.
// Carries AW/W/B write channels and AR/R read channels; master drives i_*, slave drives o_*.
interface axi4_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      i_awvalid;
    logic                      o_awready;
    logic [ADDR_WIDTH-1:0]     i_awaddr;
    logic [7:0]                i_awlen;
    logic                      i_wvalid;
    logic                      o_wready;
    logic [DATA_WIDTH-1:0]     i_wdata;
    logic [DATA_WIDTH/8-1:0]   i_wstrb;
    logic                      i_wlast;
    logic                      o_bvalid;
    logic                      i_bready;
    logic [1:0]                o_bresp;
    logic                      i_arvalid;
    logic                      o_arready;
    logic [ADDR_WIDTH-1:0]     i_araddr;
    logic [7:0]                i_arlen;
    logic                      o_rvalid;
    logic                      i_rready;
    logic [DATA_WIDTH-1:0]     o_rdata;
    logic                      o_rlast;
    logic [1:0]                o_rresp;

    modport master (
        output i_awvalid, i_awaddr, i_awlen,
        output i_wvalid, i_wdata, i_wstrb, i_wlast,
        output i_bready,
        output i_arvalid, i_araddr, i_arlen,
        output i_rready,
        input  o_awready, o_wready, o_bvalid, o_bresp,
        input  o_arready, o_rvalid, o_rdata, o_rlast, o_rresp
    );

    modport slave (
        input  i_awvalid, i_awaddr, i_awlen,
        input  i_wvalid, i_wdata, i_wstrb, i_wlast,
        input  i_bready,
        input  i_arvalid, i_araddr, i_arlen,
        input  i_rready,
        output o_awready, o_wready, o_bvalid, o_bresp,
        output o_arready, o_rvalid, o_rdata, o_rlast, o_rresp
    );
endinterface

// File: rtl/axi4_mem_responder.sv
// AXI4 memory responder: serves one INCR read or write burst at a time from a word array.
// Ports: clk, arstn (async active-low), bus (slave modport of axi4_mem_responder_if).
module axi4_mem_responder #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_DEPTH    = 4096,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  arstn,
    axi4_mem_responder_if.slave   bus
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int LB    = $clog2(LANES);
    localparam int IW    = ADDR_WIDTH - LB;
    localparam int MW    = $clog2(MEM_DEPTH);
    localparam logic [3:0] LAT_LAST = 4'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        R_WAIT,
        R_DATA,
        W_DATA,
        W_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      beat_q, beat_d;
    logic [3:0]      lat_q, lat_d;
    logic            err_q, err_d;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] mem_rd;
    logic                  mem_we;
    logic                  in_range;
    logic                  last_beat;
    logic                  unused_addr_lsb;

    // Sub-word address bits select nothing: every beat is one full word.
    assign unused_addr_lsb = ^{bus.i_awaddr[LB-1:0], bus.i_araddr[LB-1:0]};

    assign in_range  = idx_q < IW'(MEM_DEPTH);
    assign last_beat = beat_q == len_q;
    assign mem_rd    = mem[idx_q[MW-1:0]];

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            lat_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            err_q   <= err_d;
        end
    end

    // Backing store is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < LANES; b++) begin
                if (bus.i_wstrb[b]) begin
                    mem[idx_q[MW-1:0]][8*b +: 8] <= bus.i_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        len_d         = len_q;
        beat_d        = beat_q;
        lat_d         = lat_q;
        err_d         = err_q;
        mem_we        = 1'b0;
        bus.o_awready = 1'b0;
        bus.o_arready = 1'b0;
        bus.o_wready  = 1'b0;
        bus.o_bvalid  = 1'b0;
        bus.o_bresp   = 2'b00;
        bus.o_rvalid  = 1'b0;
        bus.o_rdata   = '0;
        bus.o_rlast   = 1'b0;
        bus.o_rresp   = 2'b00;

        unique case (state_q)
            IDLE: begin
                // Readies are gated by reset so they read 0 while arstn is low.
                bus.o_awready = arstn;
                bus.o_arready = arstn & ~bus.i_awvalid;
                if (bus.i_awvalid) begin
                    idx_d   = bus.i_awaddr[ADDR_WIDTH-1:LB];
                    len_d   = bus.i_awlen;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = W_DATA;
                end else if (bus.i_arvalid) begin
                    idx_d   = bus.i_araddr[ADDR_WIDTH-1:LB];
                    len_d   = bus.i_arlen;
                    beat_d  = '0;
                    lat_d   = '0;
                    state_d = (READ_LATENCY == 0) ? R_DATA : R_WAIT;
                end
            end
            R_WAIT: begin
                lat_d = lat_q + 4'd1;
                if (lat_q == LAT_LAST) begin
                    state_d = R_DATA;
                end
            end
            R_DATA: begin
                // Outputs derive from state held until rready, so they stay stable.
                bus.o_rvalid = 1'b1;
                bus.o_rdata  = in_range ? mem_rd : '0;
                bus.o_rresp  = in_range ? 2'b00 : 2'b10;
                bus.o_rlast  = last_beat;
                if (bus.i_rready) begin
                    idx_d  = idx_q + IW'(1);
                    beat_d = beat_q + 8'd1;
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            W_DATA: begin
                bus.o_wready = 1'b1;
                if (bus.i_wvalid) begin
                    mem_we = in_range;
                    if (!in_range || (bus.i_wlast != last_beat)) begin
                        err_d = 1'b1;
                    end
                    idx_d  = idx_q + IW'(1);
                    beat_d = beat_q + 8'd1;
                    if (last_beat) begin
                        state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                bus.o_bvalid = 1'b1;
                bus.o_bresp  = err_q ? 2'b10 : 2'b00;
                if (bus.i_bready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed bench for axi4_mem_responder: burst write/read, backpressure, strobes, ties, errors, reset.
// Single-word strobe cases come from a vector table; multi-cycle cases are hand sequences.
module tb_axi4_mem_responder;
    logic clk;
    logic arstn;
    int   checks;
    int   failures;

    axi4_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi4_mem_responder #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MEM_DEPTH(4096),
        .READ_LATENCY(2)
    ) dut (
        .clk(clk),
        .arstn(arstn),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] init;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [5];

    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    int          rd_n;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                            input logic [31:0] base, input logic [3:0] strb,
                            input int last_at, output logic [1:0] bresp);
        int g;
        bus.i_awvalid = 1'b1;
        bus.i_awaddr  = addr;
        bus.i_awlen   = len;
        g = 0;
        #1;
        while (!bus.o_awready && g < 50) begin
            step();
            g++;
        end
        chk("aw_ready", {31'd0, bus.o_awready}, 32'd1);
        step();
        bus.i_awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            bus.i_wvalid = 1'b1;
            bus.i_wdata  = base + b;
            bus.i_wstrb  = strb;
            bus.i_wlast  = (b == last_at);
            #1;
            if (!bus.o_wready) begin
                chk("w_ready", {31'd0, bus.o_wready}, 32'd1);
            end
            step();
        end
        bus.i_wvalid = 1'b0;
        bus.i_wlast  = 1'b0;
        chk("bvalid_after_last_w", {31'd0, bus.o_bvalid}, 32'd1);
        bresp = bus.o_bresp;
        bus.i_bready = 1'b1;
        step();
        bus.i_bready = 1'b0;
        chk("bvalid_drop", {31'd0, bus.o_bvalid}, 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                           input int mode, output int lat, output int span);
        int g;
        int k;
        logic        hold;
        logic [31:0] hd;
        logic        hl;
        logic [1:0]  hr;
        bus.i_arvalid = 1'b1;
        bus.i_araddr  = addr;
        bus.i_arlen   = len;
        bus.i_rready  = 1'b0;
        rd_n = 0;
        g = 0;
        #1;
        while (!bus.o_arready && g < 50) begin
            step();
            g++;
        end
        chk("ar_ready", {31'd0, bus.o_arready}, 32'd1);
        step();
        bus.i_arvalid = 1'b0;
        lat = 1;
        while (!bus.o_rvalid && lat < 50) begin
            step();
            lat++;
        end
        k = 0;
        hold = 1'b0;
        hd = '0;
        hl = 1'b0;
        hr = '0;
        while (rd_n < int'(len) + 1 && k < 200) begin
            bus.i_rready = (mode == 0) ? 1'b1 : (k % 3 == 0);
            #1;
            if (hold) begin
                chk("hold_rvalid", {31'd0, bus.o_rvalid}, 32'd1);
                chk("hold_rdata", bus.o_rdata, hd);
                chk("hold_rlast", {31'd0, bus.o_rlast}, {31'd0, hl});
                chk("hold_rresp", {30'd0, bus.o_rresp}, {30'd0, hr});
                hold = 1'b0;
            end
            if (bus.o_rvalid && bus.i_rready) begin
                rd_data[rd_n] = bus.o_rdata;
                rd_resp[rd_n] = bus.o_rresp;
                rd_last[rd_n] = bus.o_rlast;
                rd_n++;
            end else if (bus.o_rvalid) begin
                hold = 1'b1;
                hd = bus.o_rdata;
                hl = bus.o_rlast;
                hr = bus.o_rresp;
            end
            k++;
            step();
        end
        span = k;
        bus.i_rready = 1'b0;
        chk("read_beats", rd_n, int'(len) + 1);
        chk("rvalid_drop", {31'd0, bus.o_rvalid}, 32'd0);
    endtask

    logic [1:0] br;
    int lat;
    int span;

    initial begin
        checks = 0;
        failures = 0;
        vecs[0] = '{32'h300, 32'h11223344, 32'hDEADBEEF, 4'b0011, 32'h1122BEEF};
        vecs[1] = '{32'h304, 32'h11223344, 32'hDEADBEEF, 4'b1100, 32'hDEAD3344};
        vecs[2] = '{32'h308, 32'h00000000, 32'hCAFEF00D, 4'b0000, 32'h00000000};
        vecs[3] = '{32'h30D, 32'hFFFFFFFF, 32'h12345678, 4'b0100, 32'hFF34FFFF};
        vecs[4] = '{32'h310, 32'hAAAAAAAA, 32'h55555555, 4'b1001, 32'h55AAAA55};

        arstn = 1'b0;
        bus.i_awvalid = 1'b0; bus.i_awaddr = '0; bus.i_awlen = '0;
        bus.i_wvalid = 1'b0; bus.i_wdata = '0; bus.i_wstrb = '0; bus.i_wlast = 1'b0;
        bus.i_bready = 1'b0;
        bus.i_arvalid = 1'b0; bus.i_araddr = '0; bus.i_arlen = '0;
        bus.i_rready = 1'b0;
        step();
        step();
        chk("rst_awready", {31'd0, bus.o_awready}, 32'd0);
        chk("rst_arready", {31'd0, bus.o_arready}, 32'd0);
        chk("rst_rvalid", {31'd0, bus.o_rvalid}, 32'd0);
        chk("rst_bvalid", {31'd0, bus.o_bvalid}, 32'd0);
        chk("rst_wready", {31'd0, bus.o_wready}, 32'd0);
        chk("rst_rdata", bus.o_rdata, 32'd0);
        chk("rst_rlast", {31'd0, bus.o_rlast}, 32'd0);
        arstn = 1'b1;
        step();
        chk("idle_awready", {31'd0, bus.o_awready}, 32'd1);
        chk("idle_arready", {31'd0, bus.o_arready}, 32'd1);

        // Line write then back-to-back read.
        do_write(32'h100, 8'd3, 32'hA0, 4'hF, 3, br);
        chk("line_bresp", {30'd0, br}, 32'd0);
        do_read(32'h100, 8'd3, 0, lat, span);
        chk("read_latency", lat, 3);
        chk("read_span", span, 4);
        for (int i = 0; i < 4; i++) begin
            chk("line_rdata", rd_data[i], 32'hA0 + i);
            chk("line_rresp", {30'd0, rd_resp[i]}, 32'd0);
            chk("line_rlast", {31'd0, rd_last[i]}, (i == 3) ? 32'd1 : 32'd0);
        end

        // Backpressure.
        do_read(32'h100, 8'd3, 1, lat, span);
        for (int i = 0; i < 4; i++) begin
            chk("bp_rdata", rd_data[i], 32'hA0 + i);
            chk("bp_rlast", {31'd0, rd_last[i]}, (i == 3) ? 32'd1 : 32'd0);
        end

        // Strobe vector table.
        for (int v = 0; v < 5; v++) begin
            do_write(vecs[v].addr, 8'd0, vecs[v].init, 4'hF, 0, br);
            do_write(vecs[v].addr, 8'd0, vecs[v].wdata, vecs[v].strb, 0, br);
            chk("strb_bresp", {30'd0, br}, 32'd0);
            do_read(vecs[v].addr, 8'd0, 0, lat, span);
            chk("strb_rdata", rd_data[0], vecs[v].exp);
            chk("strb_rlast", {31'd0, rd_last[0]}, 32'd1);
        end

        // AW and AR in the same cycle: write wins, read sees its data.
        bus.i_awvalid = 1'b1;
        bus.i_awaddr  = 32'h200;
        bus.i_awlen   = 8'd1;
        bus.i_arvalid = 1'b1;
        bus.i_araddr  = 32'h200;
        bus.i_arlen   = 8'd1;
        #1;
        chk("tie_awready", {31'd0, bus.o_awready}, 32'd1);
        chk("tie_arready", {31'd0, bus.o_arready}, 32'd0);
        do_write(32'h200, 8'd1, 32'hB0, 4'hF, 1, br);
        chk("tie_bresp", {30'd0, br}, 32'd0);
        do_read(32'h200, 8'd1, 0, lat, span);
        chk("tie_rdata0", rd_data[0], 32'hB0);
        chk("tie_rdata1", rd_data[1], 32'hB1);

        // Early wlast.
        do_write(32'h240, 8'd3, 32'hC0, 4'hF, 1, br);
        chk("wlast_err_bresp", {30'd0, br}, 32'd2);

        // Read crossing the end of memory.
        do_write(32'h3FFC, 8'd0, 32'h55AA55AA, 4'hF, 0, br);
        do_read(32'h3FFC, 8'd1, 0, lat, span);
        chk("oob_rdata0", rd_data[0], 32'h55AA55AA);
        chk("oob_rresp0", {30'd0, rd_resp[0]}, 32'd0);
        chk("oob_rlast0", {31'd0, rd_last[0]}, 32'd0);
        chk("oob_rdata1", rd_data[1], 32'd0);
        chk("oob_rresp1", {30'd0, rd_resp[1]}, 32'd2);
        chk("oob_rlast1", {31'd0, rd_last[1]}, 32'd1);

        // Reset in the middle of a read burst.
        do_write(32'h400, 8'd0, 32'h0BADF00D, 4'hF, 0, br);
        bus.i_arvalid = 1'b1;
        bus.i_araddr  = 32'h100;
        bus.i_arlen   = 8'd3;
        step();
        bus.i_arvalid = 1'b0;
        lat = 0;
        while (!bus.o_rvalid && lat < 50) begin
            step();
            lat++;
        end
        chk("mid_rvalid", {31'd0, bus.o_rvalid}, 32'd1);
        bus.i_rready = 1'b1;
        step();
        bus.i_rready = 1'b0;
        chk("mid_beat2", bus.o_rdata, 32'hA1);
        arstn = 1'b0;
        #1;
        chk("mid_rst_rvalid", {31'd0, bus.o_rvalid}, 32'd0);
        chk("mid_rst_arready", {31'd0, bus.o_arready}, 32'd0);
        step();
        step();
        arstn = 1'b1;
        step();
        chk("post_rst_arready", {31'd0, bus.o_arready}, 32'd1);
        chk("post_rst_rvalid", {31'd0, bus.o_rvalid}, 32'd0);
        do_read(32'h400, 8'd0, 0, lat, span);
        chk("post_rst_word", rd_data[0], 32'h0BADF00D);
        do_read(32'h100, 8'd3, 0, lat, span);
        chk("post_rst_line0", rd_data[0], 32'hA0);
        chk("post_rst_line3", rd_data[3], 32'hA3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
